// File: rtl/julia_fb_arbiter.sv
// Frame-buffer arbiter: raster-order display prefetch into a small FIFO has
// priority; the Julia compute engine's writes get every other memory cycle.
module julia_fb_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pixel_ce,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [DATA_W-1:0] pixel_data,
  output logic              underflow,
  output logic              frame_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] NPIX    = ADDR_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {WAIT_VB, FLUSH, RUN} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  state_t            state;
  logic [9:0]        drawy_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              inflight;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count;

  logic             vblank_edge, visible, disp_req, push, pop_req, pop, fifo_empty;
  logic [CNT_W-1:0] occ;
  mem_req_t         req;

  assign vblank_edge = (DrawY == 10'(V_ACTIVE)) && (drawy_q != 10'(V_ACTIVE));
  assign visible     = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));

  // Outstanding read counts against capacity so a return always has a slot.
  assign occ        = count + CNT_W'(inflight);
  assign disp_req   = (state == RUN) && (rd_addr < NPIX) && (occ < DEPTH_C);
  assign push       = inflight && (state != FLUSH);
  assign fifo_empty = (count == '0);
  assign pop_req    = (state == RUN) && pixel_ce && visible;
  assign pop        = pop_req && !fifo_empty;

  always_comb begin
    req = '{we: wr_valid, addr: wr_addr, wdata: wr_data};
    if (disp_req) begin
      req.we   = 1'b0;
      req.addr = rd_addr;
    end
  end

  assign wr_ready  = !disp_req;
  assign mem_addr  = req.addr;
  assign mem_we    = req.we;
  assign mem_wdata = req.wdata;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= WAIT_VB;
      frame_start <= 1'b0;
      drawy_q     <= '0;
    end else begin
      drawy_q     <= DrawY;
      frame_start <= 1'b0;
      case (state)
        WAIT_VB, RUN: if (vblank_edge) begin
          state       <= FLUSH;
          frame_start <= 1'b1;
        end
        FLUSH:   state <= RUN;
        default: state <= WAIT_VB;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_addr    <= '0;
      inflight   <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      pixel_data <= '0;
      underflow  <= 1'b0;
    end else if (state == FLUSH) begin
      // A read issued just before the flush returns now and is dropped.
      rd_addr    <= '0;
      inflight   <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      pixel_data <= '0;
    end else begin
      inflight <= disp_req;
      if (disp_req) rd_addr <= rd_addr + ADDR_W'(1);
      if (push)     wptr    <= wptr + PTR_W'(1);
      if (pop)      rptr    <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (state != RUN) begin
        pixel_data <= '0;
      end else if (pixel_ce) begin
        if (!visible) begin
          pixel_data <= '0;
        end else if (fifo_empty) begin
          pixel_data <= '0;
          underflow  <= 1'b1;
        end else begin
          pixel_data <= fifo_mem[rptr];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wptr] <= mem_rdata;
  end

  // Capacity is reserved at issue time, so a push never lands on a full FIFO.
  a_no_overflow: assert property (@(posedge Clk) disable iff (Reset)
    !(push && !pop && (count == DEPTH_C)));

endmodule

// File: tb/tb_julia_fb_arbiter.sv
// Directed bench for julia_fb_arbiter; memory model returns addr[7:0] one Clk
// after each read so the expected pixel stream is just the raster address.
module tb_julia_fb_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              pixel_ce = 1'b0;
  logic [9:0]        DrawX = '0;
  logic [9:0]        DrawY = '0;
  logic [DATA_W-1:0] pixel_data;
  logic              underflow, frame_start;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;

  julia_fb_arbiter dut (
    .Clk(Clk), .Reset(Reset), .pixel_ce(pixel_ce), .DrawX(DrawX), .DrawY(DrawY),
    .pixel_data(pixel_data), .underflow(underflow), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #10 Clk = ~Clk;

  always @(posedge Clk) mem_rdata <= mem_addr[7:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_od [5];
    exp_od = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02};

    // reset release
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_pixel_data", pixel_data, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_frame_start", frame_start, 0);

    // writes while waiting for vblank
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = 8'h11 + 8'(i);
      #1;
      chk("wvb_mem_we", mem_we, 1);
      chk("wvb_mem_addr", mem_addr, i);
      chk("wvb_mem_wdata", mem_wdata, 32'h11 + i);
      chk("wvb_wr_ready", wr_ready, 1);
    end

    // vblank edge -> FLUSH -> 8 back-to-back prefetch reads
    @(negedge Clk);
    wr_addr = 19'h100; wr_data = 8'hAA; DrawY = 10'd479;
    #1 chk("pre_edge_fs", frame_start, 0);
    @(negedge Clk);
    DrawY = 10'd480;
    #1 chk("edge_cycle_fs", frame_start, 0);
    @(negedge Clk);
    #1;
    chk("flush_fs", frame_start, 1);
    chk("flush_wr_ready", wr_ready, 1);
    chk("flush_mem_we", mem_we, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      #1;
      if (k == 0) chk("run_fs_low", frame_start, 0);
      chk("pf_wr_ready", wr_ready, 0);
      chk("pf_mem_addr", mem_addr, k);
      chk("pf_mem_we", mem_we, 0);
    end
    @(negedge Clk);
    #1;
    chk("pf_done_wr_ready", wr_ready, 1);
    chk("pf_done_mem_addr", mem_addr, 32'h100);
    chk("pf_done_mem_we", mem_we, 1);

    // full visible line at 25 MHz pixel rate
    DrawY = 10'd0;
    for (int x = 0; x < 640; x++) begin
      @(negedge Clk);
      pixel_ce = 1'b1; DrawX = 10'(x); wr_addr = ADDR_W'(x);
      #1 if (wr_ready) n_wr++;
      @(negedge Clk);
      pixel_ce = 1'b0;
      #1;
      chk("line_px", pixel_data, x & 32'hFF);
      if (wr_ready) n_wr++;
    end
    chk("line_underflow", underflow, 0);
    chk("line_wr_ge_320", (n_wr >= 320), 1);

    // off-screen pixel_ce: output 0, nothing popped
    @(negedge Clk);
    pixel_ce = 1'b1; DrawX = 10'd700;
    @(negedge Clk);
    pixel_ce = 1'b0;
    #1 chk("offscreen_px", pixel_data, 0);
    @(negedge Clk);
    pixel_ce = 1'b1; DrawX = 10'd0; DrawY = 10'd1;
    @(negedge Clk);
    pixel_ce = 1'b0;
    #1;
    chk("next_line_px", pixel_data, 32'h80);
    chk("next_line_uf", underflow, 0);

    // overdrive straight after a flush: empty pops underflow
    wr_valid = 1'b0;
    @(negedge Clk);
    DrawY = 10'd480;
    @(negedge Clk);
    DrawY = 10'd0;
    #1;
    chk("od_fs", frame_start, 1);
    chk("od_uf_before", underflow, 0);
    @(negedge Clk);
    pixel_ce = 1'b1; DrawX = 10'd0;
    #1 chk("od_fs_low", frame_start, 0);
    for (int j = 0; j < 5; j++) begin
      @(negedge Clk);
      DrawX = 10'(j + 1);
      #1;
      chk("od_px", pixel_data, 32'(exp_od[j]));
      if (j == 0) chk("od_underflow", underflow, 1);
    end
    @(negedge Clk);
    pixel_ce = 1'b0; DrawY = 10'd480;
    @(negedge Clk);
    #1;
    chk("od_next_fs", frame_start, 1);
    chk("od_uf_sticky", underflow, 1);

    // reset mid-run with FIFO partly filled and a read in flight
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      #1 chk("mr_fill_rd", wr_ready, 0);
    end
    @(negedge Clk);
    #1 chk("mr_pre_rst_rd", wr_ready, 0);
    Reset = 1'b1; DrawY = 10'd0;
    #1;
    chk("mr_rst_wr_ready", wr_ready, 1);
    chk("mr_rst_px", pixel_data, 0);
    chk("mr_rst_uf", underflow, 0);
    chk("mr_rst_fs", frame_start, 0);
    chk("mr_rst_mem_we", mem_we, 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      pixel_ce = 1'b1; DrawX = 10'(i); wr_valid = 1'b1; wr_addr = ADDR_W'(32'h200 + i);
      #1;
      chk("post_rst_wr_ready", wr_ready, 1);
      chk("post_rst_mem_addr", mem_addr, 32'h200 + i);
      @(negedge Clk);
      pixel_ce = 1'b0;
      #1;
      chk("post_rst_px", pixel_data, 0);
      chk("post_rst_uf", underflow, 0);
    end
    @(negedge Clk);
    DrawY = 10'd480;
    @(negedge Clk);
    #1 chk("post_rst_fs", frame_start, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
